// File: rtl/ram_bist_pkg.sv
// Shared types and pattern helper for the RAM march-style BIST.
// Optional inverted second pass is enabled by RAM_BIST_INV_PASS_EN.
package ram_bist_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int PAT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Low byte of the test word: (2*k) mod 256.
  function automatic logic [PAT_W-1:0] pat_byte(
    input logic [31:0] k
  );
    return PAT_W'(k << 1);
  endfunction

endpackage

// File: rtl/ram_bist_chk.sv
// Registered expected-data compare with sticky first-fail capture.
// Expected word and address are latched at read issue, compared next cycle.
module ram_bist_chk
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_data,
  input  logic [DATA_W-1:0] rdata,
  output logic              mismatch,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  logic              exp_valid;
  logic              fail_seen;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;

  // Only the first miscompare of a run is reported.
  assign mismatch = exp_valid && !fail_seen
                 && (rdata != exp_data);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      exp_valid <= 1'b0;
      fail_seen <= 1'b0;
      exp_addr  <= '0;
      exp_data  <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      exp_valid <= issue;
      exp_addr  <= issue_addr;
      exp_data  <= issue_data;
      if (mismatch) begin
        fail_seen <= 1'b1;
        fail_addr <= exp_addr;
        fail_data <= rdata;
      end
    end
  end

endmodule

// File: rtl/ram_bist.sv
// RAM BIST: write (2k mod 256) to every word, read back and compare.
// Define RAM_BIST_INV_PASS_EN to add a second pass with inverted data.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              mismatch;
  logic              clr;
  logic [DATA_W-1:0] exp_word;

`ifdef RAM_BIST_INV_PASS_EN
  logic inv;
`else
  localparam logic inv = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] pattern(
    input logic [ADDR_W-1:0] k,
    input logic              iv
  );
    logic [DATA_W-1:0] p;
    p = DATA_W'(pat_byte(32'(k)));
    return iv ? ~p : p;
  endfunction

  assign cnt_nxt  = cnt + ADDR_W'(1);
  assign mem_addr = cnt;
  assign clr      = (state == ST_IDLE) && start;
  assign exp_word = pattern(cnt, inv);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wdata <= '0;
`ifdef RAM_BIST_INV_PASS_EN
      inv       <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WRITE;
            cnt       <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            mem_wr    <= 1'b1;
            mem_wdata <= pattern('0, 1'b0);
`ifdef RAM_BIST_INV_PASS_EN
            inv       <= 1'b0;
`endif
          end
        end
        ST_WRITE: begin
          if (cnt == LAST) begin
            state     <= ST_READ;
            cnt       <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b1;
            mem_wdata <= '0;
          end else begin
            cnt       <= cnt_nxt;
            mem_wdata <= pattern(cnt_nxt, inv);
          end
        end
        ST_READ: begin
          if (mismatch) begin
            state  <= ST_DONE;
            cnt    <= '0;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= ST_DRAIN;
            cnt    <= '0;
            mem_rd <= 1'b0;
          end else begin
            cnt    <= cnt_nxt;
          end
        end
        ST_DRAIN: begin
          if (mismatch) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
`ifdef RAM_BIST_INV_PASS_EN
          end else if (!inv) begin
            state     <= ST_WRITE;
            cnt       <= '0;
            inv       <= 1'b1;
            mem_wr    <= 1'b1;
            mem_wdata <= pattern('0, 1'b1);
`endif
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  ram_bist_chk #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .issue     (mem_rd),
    .issue_addr(cnt),
    .issue_data(exp_word),
    .rdata     (mem_rdata),
    .mismatch  (mismatch),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: RAM model with stuck-at-1 faults and a reference model.
module tb_ram_bist;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1 << AW;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] fail_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_wr, mem_rd;

  logic [DW-1:0] mem   [N];
  logic [DW-1:0] stuck [N];

  int vectors = 0;
  int errs = 0;

  int wr_cnt, max_rd, overlap, dones;
  logic [DW-1:0] w5_first, w5_last, w200;
  bit w5_seen;

  ram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr] | stuck[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cnt++;
      if (mem_addr == 5) begin
        if (!w5_seen) w5_first = mem_wdata;
        w5_last = mem_wdata;
        w5_seen = 1'b1;
      end
      if (mem_addr == 200) w200 = mem_wdata;
    end
    if (mem_rd && int'(mem_addr) > max_rd) max_rd = int'(mem_addr);
    if (mem_wr && mem_rd) overlap++;
    if (done) dones++;
  end

  function automatic logic [31:0] pat(int k, int p);
    logic [31:0] v;
    v = 32'((2 * k) % 256);
    return (p == 1) ? ~v : v;
  endfunction

  // What a correct BIST must report for the current fault map.
  task automatic model(output bit ok, output int fa,
                       output logic [31:0] fd, output int lat,
                       output int mrd);
    logic [31:0] e, g;
    ok = 1'b1; fa = 0; fd = '0; mrd = N - 1;
    lat = PASSES * (2 * N + 1);
    for (int p = 0; p < PASSES; p++)
      for (int k = 0; k < N; k++) begin
        e = pat(k, p);
        g = e | stuck[k];
        if (ok && g != e) begin
          ok = 1'b0; fa = k; fd = g;
          lat = p * (2 * N + 1) + N + k + 2;
          if (p == 0) mrd = (k + 1 < N) ? k + 1 : N - 1;
        end
      end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) stuck[i] = '0;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; max_rd = -1; overlap = 0; dones = 0;
    w5_seen = 1'b0; w5_first = '0; w5_last = '0; w200 = '0;
  endtask

  task automatic run(input bit hold, output int cyc);
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) if (!hold) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string nm, input int cyc);
    bit ok; int fa, lat, mrd; logic [31:0] fd;
    model(ok, fa, fd, lat, mrd);
    vectors++;
    if (cyc != lat) begin
      errs++;
      $display("FAIL %s latency got %0d exp %0d", nm, cyc, lat);
    end
    vectors++;
    if (pass !== ok) begin
      errs++;
      $display("FAIL %s pass got %b exp %b", nm, pass, ok);
    end
    if (!ok) begin
      vectors++;
      if (fail_addr !== AW'(fa)) begin
        errs++;
        $display("FAIL %s fail_addr got %0d exp %0d", nm, fail_addr, fa);
      end
      vectors++;
      if (fail_data !== fd) begin
        errs++;
        $display("FAIL %s fail_data got %h exp %h", nm, fail_data, fd);
      end
      vectors++;
      if (max_rd != mrd) begin
        errs++;
        $display("FAIL %s last_read got %0d exp %0d", nm, max_rd, mrd);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (dones != 1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s done_pulse got %0d/busy %b exp 1/0", nm, dones, busy);
    end
    vectors++;
    if (overlap != 0) begin
      errs++;
      $display("FAIL %s wr_rd_overlap got %0d exp 0", nm, overlap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, pass, mem_wr, mem_rd} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctl got %b exp 00000",
               {busy, done, pass, mem_wr, mem_rd});
    end
    vectors++;
    if (fail_addr !== '0 || fail_data !== '0) begin
      errs++;
      $display("FAIL reset_fail got %h/%h exp 0/0", fail_addr, fail_data);
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errs++;
      $display("FAIL reset_mem got %h/%h exp 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    int cyc;
    clear_faults();
    run(1'b0, cyc);
    check_run("clean", cyc);
    vectors++;
    if (wr_cnt != PASSES * N) begin
      errs++;
      $display("FAIL clean wr_cycles got %0d exp %0d", wr_cnt, PASSES * N);
    end
    vectors++;
    if (w5_first !== pat(5, 0) || w200 !== pat(200, PASSES - 1)) begin
      errs++;
      $display("FAIL clean wdata got %h/%h exp %h/%h",
               w5_first, w200, pat(5, 0), pat(200, PASSES - 1));
    end
    vectors++;
    if (w5_last !== pat(5, PASSES - 1)) begin
      errs++;
      $display("FAIL clean last_w5 got %h exp %h", w5_last, pat(5, PASSES - 1));
    end
    vectors++;
    if (pass !== 1'b1) begin
      errs++;
      $display("FAIL clean pass_hold got %b exp 1", pass);
    end
  endtask

  task automatic test_stuck_300();
    int cyc;
    clear_faults();
    stuck[300] = 32'h1;
    run(1'b0, cyc);
    check_run("stuck300", cyc);
  endtask

  task automatic test_two_faults();
    int cyc;
    clear_faults();
    stuck[10] = 32'h1;
    stuck[20] = 32'h1;
    run(1'b0, cyc);
    check_run("two_faults", cyc);
  endtask

  task automatic test_random_faults();
    int cyc;
    for (int t = 0; t < 4; t++) begin
      clear_faults();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++)
        stuck[$urandom_range(0, N - 1)] |= 32'h1 << $urandom_range(0, 9);
      run(1'b0, cyc);
      check_run($sformatf("rand%0d", t), cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_faults();
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(mem_rd && mem_addr == 512) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!(mem_rd && mem_addr == 512)) begin
      errs++;
      $display("FAIL reset_mid reach got %0d exp 512", mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid abort got %b%b exp 00", busy, mem_rd);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (dones != 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid no_done got %0d exp 0", dones);
    end
    run(1'b0, cyc);
    check_run("after_reset", cyc);
  endtask

  task automatic test_start_held();
    int cyc;
    clear_faults();
    run(1'b1, cyc);
    check_run("start_held", cyc);
    repeat (20) @(negedge clk);
    vectors++;
    if (dones != 1 || busy !== 1'b0 || mem_wr !== 1'b0) begin
      errs++;
      $display("FAIL start_held idle got %0d/%b/%b exp 1/0/0",
               dones, busy, mem_wr);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    clear_faults();
    clear_mon();
    test_reset();
    test_clean();
    test_stuck_300();
    test_two_faults();
    test_random_faults();
    test_reset_mid();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
